// File: rtl/jt900h_rbank.sv
// TLCS-900H register storage: NBANKS accumulator banks, pointer registers, RFP and flag sets.
// Two registered read ports with write-first forwarding and one byte/word/long write port.
module jt900h_rbank #(
    parameter int unsigned  NBANKS  = 4,
    parameter logic [31:0]  XSP_RST = 32'h0000_0100,
    localparam int unsigned RFPW    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [7:0]      ra0,
    input  logic [7:0]      ra1,
    input  logic [1:0]      rsz0,
    input  logic [1:0]      rsz1,
    output logic [31:0]     rd0,
    output logic [31:0]     rd1,
    input  logic            we,
    input  logic [7:0]      wa,
    input  logic [1:0]      wsz,
    input  logic [31:0]     wd,
    input  logic            incf,
    input  logic            decf,
    input  logic            ld_rfp,
    input  logic [RFPW-1:0] rfp_in,
    input  logic            exff,
    input  logic [5:0]      fmask,
    input  logic [5:0]      fin,
    output logic [RFPW-1:0] rfp,
    output logic [7:0]      flags,
    output logic [7:0]      flags_alt
);

    // Physical map: bank b register r at b*4+r, pointers after the last bank.
    localparam int unsigned NREG  = NBANKS * 4 + 4;
    localparam int unsigned IW    = $clog2(NREG);
    localparam logic [RFPW-1:0] BMASK = RFPW'(NBANKS - 1);
    localparam logic [4:0]      NB5   = 5'(NBANKS);
    localparam logic [IW-1:0]   PBASE = IW'(NBANKS * 4);

    logic [31:0]     regs [NREG];
    logic [5:0]      fmain;
    logic [5:0]      falt;
    logic [IW:0]     wdec;
    logic [IW:0]     r0dec;
    logic [IW:0]     r1dec;
    logic [31:0]     wnew;
    logic [31:0]     fwd0;
    logic [31:0]     fwd1;
    logic [31:0]     rd0_c;
    logic [31:0]     rd1_c;
    logic [RFPW-1:0] rfp_nx;
    logic [5:0]      fsel;
    logic [5:0]      fnew;

    // Returns {valid, physical index}; a is address bits [7:2].
    function automatic logic [IW:0] decode(input logic [5:0] a, input logic [RFPW-1:0] r);
        logic [RFPW-1:0] bank;
        logic            ok;
        logic            ptr;
        ok   = 1'b1;
        ptr  = 1'b0;
        bank = r;
        if ({1'b0, a[5:2]} < NB5)  bank = a[2+RFPW-1:2];
        else if (a[5:2] == 4'hE)   bank = r;
        else if (a[5:2] == 4'hD)   bank = (r - RFPW'(1)) & BMASK;
        else if (a[5:2] == 4'hF)   ptr  = 1'b1;
        else                       ok   = 1'b0;
        if (!ok) return '0;
        if (ptr) return {1'b1, PBASE + IW'(a[1:0])};
        return {1'b1, IW'({bank, a[1:0]})};
    endfunction

    function automatic logic [1:0] lane(input logic [1:0] lo, input logic [1:0] sz);
        case (sz)
            2'd0:    return lo;
            2'd1:    return {lo[1], 1'b0};
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] bmask(input logic [1:0] lo, input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [1:0] lo, input logic [1:0] sz);
        logic [31:0] wsh;
        logic [3:0]  m;
        logic [31:0] res;
        wsh = data << {lane(lo, sz), 3'b000};
        m   = bmask(lo, sz);
        for (int i = 0; i < 4; i++) res[8*i +: 8] = m[i] ? wsh[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] val, input logic [1:0] lo,
                                            input logic [1:0] sz);
        logic [31:0] sh;
        sh = val >> {lane(lo, sz), 3'b000};
        case (sz)
            2'd0:    return {24'd0, sh[7:0]};
            2'd1:    return {16'd0, sh[15:0]};
            default: return val;
        endcase
    endfunction

    // Decode, write-first forwarding, RFP and flag next-state.
    always_comb begin
        wdec  = decode(wa[7:2], rfp);
        r0dec = decode(ra0[7:2], rfp);
        r1dec = decode(ra1[7:2], rfp);
        wnew  = merge(regs[wdec[IW-1:0]], wd, wa[1:0], wsz);
        fwd0  = regs[r0dec[IW-1:0]];
        fwd1  = regs[r1dec[IW-1:0]];
        if (we && wdec[IW] && (wdec == r0dec)) fwd0 = merge(fwd0, wd, wa[1:0], wsz);
        if (we && wdec[IW] && (wdec == r1dec)) fwd1 = merge(fwd1, wd, wa[1:0], wsz);
        rd0_c = r0dec[IW] ? extract(fwd0, ra0[1:0], rsz0) : 32'd0;
        rd1_c = r1dec[IW] ? extract(fwd1, ra1[1:0], rsz1) : 32'd0;

        rfp_nx = rfp;
        if (ld_rfp)            rfp_nx = rfp_in & BMASK;
        else if (incf ^ decf)  rfp_nx = incf ? ((rfp + RFPW'(1)) & BMASK)
                                             : ((rfp - RFPW'(1)) & BMASK);

        fsel = exff ? falt : fmain;
        fnew = (fsel & ~fmask) | (fin & fmask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
            regs[NREG-1] <= XSP_RST;
            rfp   <= '0;
            fmain <= '0;
            falt  <= '0;
            rd0   <= '0;
            rd1   <= '0;
        end else if (cen) begin
            if (we && wdec[IW]) regs[wdec[IW-1:0]] <= wnew;
            rfp <= rfp_nx;
            if (exff) falt <= fmain;
            fmain <= fnew;
            rd0   <= rd0_c;
            rd1   <= rd1_c;
        end
    end

    assign flags     = {fmain[5], fmain[4], 1'b0, fmain[3], 1'b0, fmain[2:0]};
    assign flags_alt = {falt[5],  falt[4],  1'b0, falt[3],  1'b0, falt[2:0]};

endmodule

// File: doc/jt900h_rbank.md
Name: jt900h_rbank

Overview:
- Parametrised successor to the fixed four-bank TLCS-900H register storage.
- Holds NBANKS banks of four 32-bit accumulators (XWA, XBC, XDE, XHL), four 32-bit pointers (XIX, XIY, XIZ, XSP), the register file pointer (RFP) and main/alternate flag sets.
- Provides two registered read ports with write-first forwarding, and one byte/word/long write port.
- Sits between the decoder/operand latch and the ALU inside the CPU core.

Parameters:
- NBANKS, 4, number of accumulator banks. Legal values: 1, 2, 4, 8. RFPW = max(1, clog2(NBANKS)).
- XSP_RST, 32'h0000_0100, reset value of XSP.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset; one clock; takes priority over cen
- cen  in  1  clock enable; when low, all state holds
- ra0, ra1  in  8  read addresses (format below)
- rsz0, rsz1  in  2  read sizes: 0 byte, 1 word, 2 long, 3 treated as long
- rd0, rd1  out  32  registered read data, zero-extended
- we  in  1  write enable
- wa  in  8  write address
- wsz  in  2  write size
- wd  in  32  write data, right-aligned
- incf, decf, ld_rfp  in  1 each  RFP controls
- rfp_in  in  RFPW  new RFP value for ld_rfp
- exff  in  1  swap main/alt flags
- fmask  in  6  per-flag write enables, order {S,Z,H,V,N,C}
- fin  in  6  flag write data
- rfp  out  RFPW  current bank
- flags  out  8  {S,Z,0,H,0,V,N,C}
- flags_alt  out  8  same layout, alternate set

Behaviour:
- Address format a[7:0], decoded with RFP as it was at the start of the cycle:
  - a[7:4] < NBANKS: absolute bank.
  - a[7:4] = 4'hE: current bank.
  - a[7:4] = 4'hD: previous bank, (RFP-1) mod NBANKS.
  - a[7:4] = 4'hF: pointers; a[3:2] selects XIX/XIY/XIZ/XSP.
  - a[3:2] selects XWA/XBC/XDE/XHL; a[1:0] is the byte lane.
  - Any other a[7:4] is invalid: reads return 0, writes are ignored.
- Size alignment:
  - Word: a[0] ignored; lane = a[1]*2.
  - Long: a[1:0] ignored.
- Reads:
  - Latency 1 cycle: rd updates on the clk edge with cen high.
  - rd = (register >> 8*lane) masked to the size; upper bits 0.
- Writes:
  - Only the addressed bytes change; other bytes hold.
  - Byte: wd[7:0]. Word: wd[15:0]. Long: wd.
- Forwarding (write-first): if we and a read hit the same physical register in the same cycle, the bytes being written are taken from wd and the rest from storage.
  - Absolute and E/D aliases of the same register must forward.
- RFP update, priority order:
  1. ld_rfp: rfp <= rfp_in mod NBANKS.
  2. incf xor decf: rfp ± 1, wrapping mod NBANKS.
  3. incf and decf both set: no change.
  - NBANKS = 1: rfp is always 0.
- Flags:
  - exff swaps the main and alt sets first; fmask/fin then write the main set using the post-swap values.
  - Bits 5 and 3 of flags/flags_alt are always 0.
- Reset: all accumulators 0; XIX/XIY/XIZ 0; XSP = XSP_RST; rfp 0; both flag sets 0; rd0/rd1 0. Any in-flight write in the reset cycle is discarded.
- cen low: no write, no RFP or flag change, rd holds.

Test Plan:
1. Reset with XSP_RST default; read ra0=8'hFC, rsz0=2 -> rd0=32'h0000_0100 one cycle later; all other registers read 0.
2. Write long 32'h1122_3344 to 8'h04 (bank0 XBC). Byte write 8'hAA to 8'h06. Read long 8'h04 -> 32'h11AA_3344; word read 8'h06 -> 32'h0000_11AA.
3. With RFP=0: we long 8'hE8 = 32'hDEAD_BEEF while ra1=8'h08, rsz1=2 in the same cycle -> rd1=32'hDEAD_BEEF (forwarding through alias). Next cycle 8'h08 still reads the same value.
4. NBANKS=4, RFP=3: incf -> rfp=0; decf -> rfp=3; incf+decf -> 3; ld_rfp=1 with incf -> 1. After that, read 8'hD0 returns bank0 XWA.
5. flags main=6'b100001, alt=0. Assert exff with fmask=6'b010000, fin=6'b010000 -> flags=8'h40, flags_alt=8'h81.
6. NBANKS=2: write to 8'h30 is ignored and read of 8'h30 returns 0; with cen low during a write, storage is unchanged; assert rst mid-sequence -> every register reads its reset value.
